// File: rtl/tri_bus_arb_pkg.sv
// Shared constants for the tri-state bus round-robin arbiter.
// State encoding, source count and default timing parameters.
package tri_bus_arb_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  localparam int DEF_MAX_HOLD    = 8;
  localparam int DEF_TURN_CYCLES = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  function automatic logic [NUM_SRC-1:0] sel2oh(input logic [SEL_W-1:0] s);
    logic [NUM_SRC-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping 3 -> 0.
module rr_pick4
  import tri_bus_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_SRC-1:0] rot;
  logic [SEL_W-1:0]   off;

  // rot[i] is the request sitting i positions above ptr
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rot[i] = req[SEL_W'(ptr + SEL_W'(i))];
    end
  end

  always_comb begin
    off = '0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign valid = |req;
  assign idx   = SEL_W'(ptr + off);

endmodule

// File: rtl/tri_bus_rr_arbiter.sv
// Round-robin owner selection for a 4-source tri-state bus with turnaround
// gap and hold cap. Define ARB_LOCK_EN to add the lock input.
module tri_bus_rr_arbiter
  import tri_bus_arb_pkg::*;
#(
  parameter int MAX_HOLD    = DEF_MAX_HOLD,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_SRC-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               bus_en,
  output logic               busy
);

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

  logic [1:0]       state;
  logic [SEL_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic [3:0]       turn_cnt;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             hold_lock;
  logic             others;
  logic             preempt;
  logic             rel;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef ARB_LOCK_EN
  assign hold_lock = lock;
`else
  assign hold_lock = 1'b0;
`endif

  assign others = |(req & ~gnt);
  // >= rather than == so an owner already saturated before a competitor
  // showed up is still preempted instead of holding forever
  assign preempt = others && !hold_lock && (hold_cnt >= HOLD_LAST);
  assign rel     = !req[sel] || preempt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      sel      <= '0;
      bus_en   <= 1'b0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state    <= ST_GRANT;
            sel      <= pick_idx;
            gnt      <= sel2oh(pick_idx);
            bus_en   <= 1'b1;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            state    <= ST_TURN;
            gnt      <= '0;
            bus_en   <= 1'b0;
            ptr      <= SEL_W'(sel + 1'b1);
            turn_cnt <= TURN_LOAD;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ST_TURN: begin
          if (turn_cnt != 4'd0) begin
            turn_cnt <= turn_cnt - 4'd1;
          end else if (pick_valid) begin
            state    <= ST_GRANT;
            sel      <= pick_idx;
            gnt      <= sel2oh(pick_idx);
            bus_en   <= 1'b1;
            hold_cnt <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          gnt    <= '0;
          bus_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_bus_rr_arbiter.sv
// Scoreboard bench for tri_bus_rr_arbiter: expected outputs queued per cycle.
// Two instances: default timing, and TURN_CYCLES=3.
module tb_tri_bus_rr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       bus_en;
    logic       busy;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req3;
  logic       lock;

  logic [3:0] gnt, gnt3;
  logic [1:0] sel, sel3;
  logic       bus_en, bus_en3, busy, busy3;

  obs_t obs, obs3;
  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tri_bus_rr_arbiter #(.MAX_HOLD(8), .TURN_CYCLES(1)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
`ifdef ARB_LOCK_EN
    .lock   (lock),
`endif
    .gnt    (gnt),
    .sel    (sel),
    .bus_en (bus_en),
    .busy   (busy)
  );

  tri_bus_rr_arbiter #(.MAX_HOLD(8), .TURN_CYCLES(3)) u_dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req3),
`ifdef ARB_LOCK_EN
    .lock   (lock),
`endif
    .gnt    (gnt3),
    .sel    (sel3),
    .bus_en (bus_en3),
    .busy   (busy3)
  );

  assign obs  = {gnt, sel, bus_en, busy};
  assign obs3 = {gnt3, sel3, bus_en3, busy3};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(input logic [3:0] g, input logic [1:0] s, input logic b);
    obs_t o;
    o.gnt    = g;
    o.sel    = s;
    o.bus_en = |g;
    o.busy   = b;
    return o;
  endfunction

  // drive one cycle of stimulus, queue its expectation, check after the edge
  task automatic cyc(input int which, input logic [3:0] r, input obs_t e, input string tag);
    obs_t o, x;
    if (which == 0) req = r; else req3 = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = (which == 0) ? obs : obs3;
    x = exp_q.pop_front();
    chk(tag, 16'(o), 16'(x));
    chk({tag, "_oh"}, 16'($onehot0(o.gnt)), 16'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    req3  = '0;
    lock  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst", 16'(obs), 16'(mk(4'b0000, 2'd0, 1'b0)));
    chk("rst3", 16'(obs3), 16'(mk(4'b0000, 2'd0, 1'b0)));
    rst_n = 1'b1;

    // single requester: 1-cycle latency, holds indefinitely with no competitor
    cyc(0, 4'b0000, mk(4'b0000, 2'd0, 1'b0), "t1_idle");
    cyc(0, 4'b0100, mk(4'b0100, 2'd2, 1'b1), "t1_gnt");
    for (int i = 0; i < 12; i++) cyc(0, 4'b0100, mk(4'b0100, 2'd2, 1'b1), "t1_hold");
    cyc(0, 4'b0000, mk(4'b0000, 2'd2, 1'b1), "t1_rel");
    cyc(0, 4'b0000, mk(4'b0000, 2'd2, 1'b0), "t1_back_idle");

    // all four requesting: rotation with 8-cycle preemption and 1-cycle gap
    do_reset();
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      for (int j = 0; j < 8; j++)
        cyc(0, 4'b1111, mk(4'(1 << o), 2'(o), 1'b1), "t2_own");
      if (k < 4) cyc(0, 4'b1111, mk(4'b0000, 2'(o), 1'b1), "t2_gap");
    end
    cyc(0, 4'b0000, mk(4'b0000, 2'd0, 1'b1), "t2_rel");
    cyc(0, 4'b0000, mk(4'b0000, 2'd0, 1'b0), "t2_idle");

    // owner 1 drops early while 3 waits
    for (int i = 0; i < 3; i++) cyc(0, 4'b1010, mk(4'b0010, 2'd1, 1'b1), "t3_own1");
    cyc(0, 4'b1000, mk(4'b0000, 2'd1, 1'b1), "t3_gap");
    cyc(0, 4'b1000, mk(4'b1000, 2'd3, 1'b1), "t3_own3");
    cyc(0, 4'b1000, mk(4'b1000, 2'd3, 1'b1), "t3_own3b");
    cyc(0, 4'b0000, mk(4'b0000, 2'd3, 1'b1), "t3_rel");
    cyc(0, 4'b0000, mk(4'b0000, 2'd3, 1'b0), "t3_idle");

    // three-cycle turnaround with no follow-on request
    cyc(1, 4'b0001, mk(4'b0001, 2'd0, 1'b1), "t4_gnt");
    cyc(1, 4'b0000, mk(4'b0000, 2'd0, 1'b1), "t4_turn0");
    cyc(1, 4'b0000, mk(4'b0000, 2'd0, 1'b1), "t4_turn1");
    cyc(1, 4'b0000, mk(4'b0000, 2'd0, 1'b1), "t4_turn2");
    cyc(1, 4'b0000, mk(4'b0000, 2'd0, 1'b0), "t4_idle");

    // asynchronous reset in the middle of a grant
    cyc(0, 4'b0010, mk(4'b0010, 2'd1, 1'b1), "t5_gnt");
    cyc(0, 4'b0010, mk(4'b0010, 2'd1, 1'b1), "t5_gnt2");
    rst_n = 1'b0;
    #1;
    chk("t5_async", 16'(obs), 16'(mk(4'b0000, 2'd0, 1'b0)));
    #2;
    rst_n = 1'b1;
    cyc(0, 4'b1010, mk(4'b0010, 2'd1, 1'b1), "t5_regrant");
    cyc(0, 4'b0000, mk(4'b0000, 2'd1, 1'b1), "t5_rel");
    cyc(0, 4'b0000, mk(4'b0000, 2'd1, 1'b0), "t5_idle");

`ifdef ARB_LOCK_EN
    // lock suppresses preemption; only dropping req releases
    do_reset();
    lock = 1'b1;
    for (int i = 0; i < 12; i++) cyc(0, 4'b0011, mk(4'b0001, 2'd0, 1'b1), "t6_lock");
    cyc(0, 4'b0010, mk(4'b0000, 2'd0, 1'b1), "t6_gap");
    cyc(0, 4'b0010, mk(4'b0010, 2'd1, 1'b1), "t6_own1");
    lock = 1'b0;
    cyc(0, 4'b0000, mk(4'b0000, 2'd1, 1'b1), "t6_rel");
    cyc(0, 4'b0000, mk(4'b0000, 2'd1, 1'b0), "t6_idle");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
